// File: rtl/uio_bus_arbiter.sv
// Round-robin arbiter sharing the 8-bit bidirectional uio pad bus among N_REQ requesters.
// Single-byte drive/sample grants, with turnaround on direction change and idle parking.
module uio_bus_arbiter #(
  parameter int unsigned N_REQ    = 3,
  parameter int unsigned TURN_CYC = 1,
  parameter int unsigned PARK_CYC = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ena,
  input  logic [N_REQ-1:0]     req,
  input  logic [N_REQ-1:0]     dir,
  input  logic [8*N_REQ-1:0]   wdata,
  output logic [N_REQ-1:0]     grant,
  output logic [N_REQ-1:0]     rvalid,
  output logic [7:0]           rdata,
  output logic                 busy,
  input  logic [7:0]           uio_in,
  output logic [7:0]           uio_out,
  output logic [7:0]           uio_oe
);

  localparam int unsigned IDX_W  = $clog2(N_REQ);
  localparam int unsigned TURN_W = 3;
  localparam int unsigned PARK_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TURN = 2'd1,
    XFER = 2'd2
  } state_t;

  state_t                      state_q, state_d;
  logic [IDX_W-1:0]            win_q, win_d;
  logic [IDX_W-1:0]            last_q, last_d;
  logic                        win_dir_q, win_dir_d;
  logic [7:0]                  win_byte_q, win_byte_d;
  logic [TURN_W-1:0]           turn_q, turn_d;
  logic [PARK_W-1:0]           park_q, park_d;
  logic [N_REQ-1:0]            grant_q, grant_d;
  logic [N_REQ-1:0]            rvalid_q, rvalid_d;
  logic [7:0]                  rdata_q, rdata_d;
  logic [7:0]                  out_q, out_d;
  logic [7:0]                  oe_q, oe_d;
  logic                        busy_q, busy_d;

  logic [N_REQ-1:0][7:0]       wbytes;
  logic [IDX_W-1:0]            pick;
  logic [IDX_W-1:0]            cand;
  logic                        found;
  logic                        bus_wr;

  assign wbytes = wdata;
  assign bus_wr = (oe_q == 8'hFF);

  // Round-robin search starting one past the last granted requester
  always_comb begin
    found = 1'b0;
    pick  = last_q;
    cand  = last_q;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      cand = IDX_W'((32'(last_q) + k) % N_REQ);
      if (!found && req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d    = state_q;
    win_d      = win_q;
    last_d     = last_q;
    win_dir_d  = win_dir_q;
    win_byte_d = win_byte_q;
    turn_d     = turn_q;
    park_d     = park_q;
    grant_d    = '0;
    rvalid_d   = '0;
    rdata_d    = rdata_q;
    out_d      = out_q;
    oe_d       = oe_q;
    busy_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (ena && found) begin
          win_d      = pick;
          win_dir_d  = dir[pick];
          win_byte_d = wbytes[pick];
          park_d     = '0;
          busy_d     = 1'b1;
          if (dir[pick] == bus_wr) begin
            state_d = XFER;
            grant_d = N_REQ'(1) << pick;
            if (dir[pick]) begin
              oe_d  = 8'hFF;
              out_d = wbytes[pick];
            end else begin
              oe_d  = 8'h00;
            end
          end else begin
            state_d = TURN;
            turn_d  = '0;
            oe_d    = 8'h00;
          end
        end else begin
          if (park_q != PARK_W'(PARK_CYC)) begin
            park_d = park_q + PARK_W'(1);
          end
          if (!ena || (park_d == PARK_W'(PARK_CYC))) begin
            oe_d  = 8'h00;
            out_d = 8'h00;
          end
        end
      end

      TURN: begin
        busy_d = 1'b1;
        oe_d   = 8'h00;
        if (turn_q == TURN_W'(TURN_CYC - 1)) begin
          state_d = XFER;
          grant_d = N_REQ'(1) << win_q;
          if (win_dir_q) begin
            oe_d  = 8'hFF;
            out_d = win_byte_q;
          end
        end else begin
          turn_d = turn_q + TURN_W'(1);
        end
      end

      XFER: begin
        state_d = IDLE;
        last_d  = win_q;
        if (!win_dir_q) begin
          rvalid_d = N_REQ'(1) << win_q;
          rdata_d  = uio_in;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      win_q      <= '0;
      last_q     <= IDX_W'(N_REQ - 1);
      win_dir_q  <= 1'b0;
      win_byte_q <= 8'h00;
      turn_q     <= '0;
      park_q     <= '0;
      grant_q    <= '0;
      rvalid_q   <= '0;
      rdata_q    <= 8'h00;
      out_q      <= 8'h00;
      oe_q       <= 8'h00;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      win_q      <= win_d;
      last_q     <= last_d;
      win_dir_q  <= win_dir_d;
      win_byte_q <= win_byte_d;
      turn_q     <= turn_d;
      park_q     <= park_d;
      grant_q    <= grant_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      out_q      <= out_d;
      oe_q       <= oe_d;
      busy_q     <= busy_d;
    end
  end

  assign grant   = grant_q;
  assign rvalid  = rvalid_q;
  assign rdata   = rdata_q;
  assign busy    = busy_q;
  assign uio_out = out_q;
  assign uio_oe  = oe_q;

endmodule

// File: tb/tb_uio_bus_arbiter.sv
// Bench for uio_bus_arbiter: transaction-schedule reference model feeds queues that a
// separate monitor drains and compares against the pad bus, grants and read results.
module tb_uio_bus_arbiter;

  localparam int N    = 3;
  localparam int TURN = 1;
  localparam int PARK = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           ena;
  logic [N-1:0]   req;
  logic [N-1:0]   dir;
  logic [7:0]     wb [N];
  logic [8*N-1:0] wdata;
  logic [N-1:0]   grant;
  logic [N-1:0]   rvalid;
  logic [7:0]     rdata;
  logic           busy;
  logic [7:0]     uio_in;
  logic [7:0]     uio_out;
  logic [7:0]     uio_oe;

  assign wdata = {wb[2], wb[1], wb[0]};

  always #5 clk = ~clk;

  uio_bus_arbiter #(.N_REQ(N), .TURN_CYC(TURN), .PARK_CYC(PARK)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .req     (req),
    .dir     (dir),
    .wdata   (wdata),
    .grant   (grant),
    .rvalid  (rvalid),
    .rdata   (rdata),
    .busy    (busy),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  typedef struct {
    int         e;
    logic [7:0] oe;
    logic [7:0] out;
    logic       busy;
    logic [7:0] rdata;
  } pad_t;

  typedef struct {
    int         e;
    logic [N-1:0] onehot;
    logic [7:0] data;
  } txn_t;

  pad_t pad_q [$];
  txn_t gnt_q [$];
  txn_t rd_q  [$];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: schedules whole transactions from the arbitration rules
  int         m_edge = 0;
  int         m_next_arb = 1;
  int         m_xfer_e = -1;
  int         m_rd_e = -1;
  int         m_last = N - 1;
  int         m_idle = 0;
  int         m_w = 0;
  logic       m_wdir = 1'b0;
  logic [7:0] m_byte = 8'h00;
  logic [7:0] m_oe = 8'h00;
  logic [7:0] m_out = 8'h00;
  logic [7:0] m_rdata = 8'h00;

  task automatic model_step();
    pad_t p;
    txn_t t;
    int   w;
    int   tc;
    m_edge++;
    if (!rst_n) begin
      m_oe = 8'h00; m_out = 8'h00; m_rdata = 8'h00;
      m_last = N - 1; m_idle = 0;
      m_next_arb = m_edge + 1; m_xfer_e = -1; m_rd_e = -1;
    end else begin
      if (m_edge == m_rd_e) begin
        m_rdata = uio_in;
        t.e = m_edge; t.onehot = N'(1) << m_w; t.data = uio_in;
        rd_q.push_back(t);
        m_rd_e = -1;
      end
      if (m_edge >= m_next_arb) begin
        if (ena && req != '0) begin
          w = -1;
          for (int off = 1; off <= N; off++) begin
            if (w < 0 && req[2'((m_last + off) % N)]) w = (m_last + off) % N;
          end
          m_w = w; m_wdir = dir[2'(w)]; m_byte = wb[2'(w)];
          tc = (m_wdir == (m_oe == 8'hFF)) ? 0 : TURN;
          if (tc > 0) m_oe = 8'h00;
          m_xfer_e = m_edge + tc;
          m_next_arb = m_edge + tc + 2;
          m_idle = 0;
        end else begin
          if (m_idle < PARK) m_idle++;
          if (m_idle >= PARK || !ena) begin
            m_oe = 8'h00; m_out = 8'h00;
          end
        end
      end
      if (m_edge == m_xfer_e) begin
        if (m_wdir) begin
          m_oe = 8'hFF; m_out = m_byte;
        end else begin
          m_oe = 8'h00; m_rd_e = m_edge + 1;
        end
        m_last = m_w;
        t.e = m_edge; t.onehot = N'(1) << m_w; t.data = m_out;
        gnt_q.push_back(t);
        m_xfer_e = -1;
      end
    end
    p.e = m_edge; p.oe = m_oe; p.out = m_out; p.rdata = m_rdata;
    p.busy = (m_edge <= m_next_arb - 2);
    pad_q.push_back(p);
  endtask

  // Monitor: one pad item per cycle, transaction items whenever grant/rvalid show up
  initial begin
    int   cyc;
    pad_t p;
    txn_t t;
    cyc = 0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (pad_q.size() == 0) begin
        n_checks++;
        $display("FAIL pad_underflow: got empty queue, required an entry at cycle %0d", cyc);
      end else begin
        p = pad_q.pop_front();
        check("cycle_sync", 32'(cyc), 32'(p.e));
        check("uio_oe", 32'(uio_oe), 32'(p.oe));
        check("uio_out", 32'(uio_out), 32'(p.out));
        check("busy", 32'(busy), 32'(p.busy));
        check("rdata_held", 32'(rdata), 32'(p.rdata));
      end
      if (grant != '0 || (gnt_q.size() > 0 && gnt_q[0].e <= cyc)) begin
        if (gnt_q.size() == 0) begin
          n_checks++;
          $display("FAIL grant_spurious: got %0b, required 0 at cycle %0d", grant, cyc);
        end else begin
          t = gnt_q.pop_front();
          check("grant", 32'(grant), 32'(t.onehot));
          check("grant_cycle", 32'(cyc), 32'(t.e));
        end
      end
      if (rvalid != '0 || (rd_q.size() > 0 && rd_q[0].e <= cyc)) begin
        if (rd_q.size() == 0) begin
          n_checks++;
          $display("FAIL rvalid_spurious: got %0b, required 0 at cycle %0d", rvalid, cyc);
        end else begin
          t = rd_q.pop_front();
          check("rvalid", 32'(rvalid), 32'(t.onehot));
          check("rdata", 32'(rdata), 32'(t.data));
          check("rvalid_cycle", 32'(cyc), 32'(t.e));
        end
      end
    end
  end

  task automatic step();
    model_step();
    @(negedge clk);
  endtask

  // Hold each masked request until its own grant bit is seen
  task automatic serve(input logic [N-1:0] mask, input int bound);
    logic [N-1:0] pend;
    int           n;
    pend = mask;
    n    = 0;
    req  = pend;
    while (pend != '0 && n < bound) begin
      step();
      n++;
      pend = pend & ~grant;
      req  = pend;
    end
    check("serve_done", 32'(pend), 32'(0));
  endtask

  initial begin
    logic [N-1:0] act;
    int           rate;
    int           n;

    rst_n = 1'b0; ena = 1'b1; req = '0; dir = '0; uio_in = 8'h5A;
    for (int i = 0; i < N; i++) wb[i] = 8'h00;
    step(); step();
    rst_n = 1'b1;
    step();

    // First write needs a turnaround, the next one from the same side does not
    dir = 3'b001; wb[0] = 8'hA5;
    serve(3'b001, 20);
    step();
    wb[0] = 8'h3C;
    serve(3'b001, 20);

    // Read by requester 1 on a driven bus
    dir = 3'b000; uio_in = 8'h5A;
    serve(3'b010, 20);
    step(); step();

    // All three writing: strict rotation
    dir = 3'b111; wb[0] = 8'h11; wb[1] = 8'h22; wb[2] = 8'h33;
    serve(3'b111, 40);

    // Idle parking, then ena-driven parking
    repeat (6) step();
    dir = 3'b001; wb[0] = 8'h77;
    serve(3'b001, 20);
    ena = 1'b0;
    repeat (2) step();
    ena = 1'b1;

    // Reset during a read XFER, then requester 0 must win first
    dir = 3'b000; uio_in = 8'hC3; req = 3'b010; n = 0;
    while (!grant[1] && n < 20) begin
      step();
      n++;
    end
    check("read_granted", 32'(grant[1]), 32'(1));
    rst_n = 1'b0; req = '0;
    step();
    rst_n = 1'b1;
    step();
    dir = 3'b111; wb[0] = 8'h9E; wb[1] = 8'h4D;
    serve(3'b011, 20);

    // Randomized traffic with occasional ena drops and resets
    act  = '0;
    rate = 2;
    for (int c = 0; c < 3000; c++) begin
      if (c % 500 == 0) rate = $urandom_range(1, 6);
      act = act & ~grant;
      for (int i = 0; i < N; i++) begin
        if (!act[i] && $urandom_range(0, rate) == 0) act[i] = 1'b1;
        dir[i] = 1'($urandom);
        wb[i]  = 8'($urandom);
      end
      req    = act;
      ena    = ($urandom_range(0, 15) != 0);
      rst_n  = ($urandom_range(0, 249) != 0);
      uio_in = 8'($urandom);
      step();
    end

    req = '0; ena = 1'b1; rst_n = 1'b1;
    repeat (12) step();
    check("grant_queue_drained", 32'(gnt_q.size()), 32'(0));
    check("read_queue_drained", 32'(rd_q.size()), 32'(0));
    check("pad_queue_drained", 32'(pad_q.size()), 32'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
